mem_access: RTL and testbench

//  Memory stage of the multi-cycle core, directly upstream of writeback. Takes one instruction per
//  en pulse. Loads and stores run as byte-serial little-endian transfers on an 8-bit req/ack bus.
//  All other ops pass result_in through. Presents op/funct3/reg_addr/val with a one-cycle ready

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_access.sv | 139 +++++++++++++
 tb/tb_mem_access.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Memory-stage shared definitions: opcodes, access sizes,
// FSM states and small decode helpers.
package mem_access_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] MEM_ACC_8  = 2'b00;
  localparam logic [1:0] MEM_ACC_16 = 2'b01;
  localparam logic [1:0] MEM_ACC_32 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mem_op(
    input logic [6:0] op
  );
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Index of the final byte; 2'b11 is treated as a word.
  function automatic logic [1:0] last_idx(
    input logic [1:0] acc
  );
    logic [1:0] r;
    r = 2'd3;
    unique case (1'b1)
      (acc == MEM_ACC_8):  r = 2'd0;
      (acc == MEM_ACC_16): r = 2'd1;
      default:             r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory stage: byte-serial little-endian loads/stores
// on an 8-bit req/ack bus; other ops pass through.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [6:0]            op_in,
  input  logic [2:0]            funct3_in,
  input  logic [3:0]            rd_in,
  input  logic [XLEN-1:0]       result_in,
  input  logic [XLEN-1:0]       store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  output logic [6:0]            op,
  output logic [2:0]            funct3,
  output logic [3:0]            reg_addr,
  output logic [XLEN-1:0]       val,
  output logic                  ready
);

  state_e r_state;
  state_e w_next;

  logic [6:0]            r_op;
  logic [2:0]            r_funct3;
  logic [3:0]            r_rd;
  logic [XLEN-1:0]       r_val;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [XLEN-1:0]       r_sdata;
  logic [1:0]            r_idx;
  logic [1:0]            r_last;
  logic                  r_is_store;

  logic                  w_start;
  logic                  w_ack;
  logic                  w_last_ack;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_wbyte;

  assign w_start    = (r_state == ST_IDLE) && en;
  assign w_ack      = (r_state == ST_XFER) && mem_ack;
  assign w_last_ack = w_ack && (r_idx == r_last);
  assign w_addr     = r_addr + ADDR_WIDTH'(r_idx);
  assign w_wbyte    = r_sdata[{r_idx, 3'b000} +: 8];

  assign op       = r_op;
  assign funct3   = r_funct3;
  assign reg_addr = r_rd;
  assign val      = r_val;

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE -> XFER/DONE, XFER -> DONE on last ack.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_next = is_mem_op(op_in) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (w_last_ack) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus drive while transferring; ready pulse in DONE.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ready     = 1'b0;
    unique case (1'b1)
      (r_state == ST_XFER): begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        mem_addr  = w_addr;
        mem_wdata = w_wbyte;
      end
      (r_state == ST_DONE): begin
        ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Latch the instruction on start; step bytes on ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_val      <= '0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_is_store <= 1'b0;
    end else if (w_start) begin
      r_op       <= op_in;
      r_funct3   <= funct3_in;
      r_rd       <= rd_in;
      r_addr     <= ADDR_WIDTH'(result_in);
      r_sdata    <= store_data;
      r_idx      <= '0;
      r_last     <= last_idx(funct3_in[1:0]);
      r_is_store <= (op_in == OP_STORE);
      r_val      <= is_mem_op(op_in) ? '0 : result_in;
    end else if (w_ack) begin
      if (!r_is_store) begin
        r_val[{r_idx, 3'b000} +: 8] <= mem_rdata;
      end
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a
// transaction-level model with a byte memory.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [6:0]  op_in;
  logic [2:0]  funct3_in;
  logic [3:0]  rd_in;
  logic [31:0] result_in;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [3:0]  reg_addr;
  logic [31:0] val;
  logic        ready;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .op_in(op_in), .funct3_in(funct3_in),
    .rd_in(rd_in), .result_in(result_in),
    .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .op(op), .funct3(funct3),
    .reg_addr(reg_addr), .val(val),
    .ready(ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } bus_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  rd;
    logic [31:0] val;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  res_t hold;
  bit   hold_on;
  logic [7:0] mem [logic [31:0]];

  int cyc = 0;
  int bus_start;
  int exp_ready_at;
  int wait_left;
  int fixed_wait;
  bit chk_en;
  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int pick_wait();
    if (fixed_wait >= 0) return fixed_wait;
    if ($urandom_range(0, 3) == 0) return $urandom_range(1, 3);
    return 0;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare plus bus responder.
  always @(negedge clk) begin
    bit   exp_req;
    bus_t b;
    res_t r;
    exp_req = (bus_q.size() > 0) && (cyc >= bus_start);
    if (chk_en) begin
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (exp_req && mem_req) begin
        chk("mem_addr", mem_addr, bus_q[0].addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, bus_q[0].we});
        if (bus_q[0].we)
          chk("mem_wdata", {24'd0, mem_wdata},
              {24'd0, bus_q[0].wdata});
      end
      chk("ready", {31'd0, ready},
          {31'd0, cyc == exp_ready_at});
      if (ready && cyc == exp_ready_at && res_q.size() > 0) begin
        r = res_q.pop_front();
        chk("op", {25'd0, op}, {25'd0, r.op});
        chk("funct3", {29'd0, funct3}, {29'd0, r.f3});
        chk("reg_addr", {28'd0, reg_addr}, {28'd0, r.rd});
        chk("val", val, r.val);
        hold    = r;
        hold_on = 1;
      end else if (hold_on) begin
        chk("hold_op", {25'd0, op}, {25'd0, hold.op});
        chk("hold_f3", {29'd0, funct3}, {29'd0, hold.f3});
        chk("hold_rd", {28'd0, reg_addr}, {28'd0, hold.rd});
        chk("hold_val", val, hold.val);
      end
    end
    if (chk_en && mem_req && exp_req) begin
      if (wait_left > 0) begin
        wait_left--;
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
      end else begin
        b = bus_q.pop_front();
        mem_ack   = 1'b1;
        mem_rdata = b.rdata;
        if (bus_q.size() == 0) exp_ready_at = cyc + 1;
        wait_left = pick_wait();
      end
    end else begin
      mem_ack   = (chk_en && !mem_req) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 8'($urandom);
    end
  end

  task automatic issue(input logic [6:0]  o,
                       input logic [2:0]  f3,
                       input logic [3:0]  rd,
                       input logic [31:0] res,
                       input logic [31:0] sd);
    res_t r;
    bus_t b;
    int   n;
    bit   mop;
    mop = (o == OP_LOAD) || (o == OP_STORE);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    r.op = o;
    r.f3 = f3;
    r.rd = rd;
    r.val = mop ? 32'd0 : res;
    if (mop) begin
      for (int k = 0; k < n; k++) begin
        b.addr  = res + 32'(k);
        b.we    = (o == OP_STORE);
        b.wdata = sd[8*k +: 8];
        b.rdata = mrd(b.addr);
        if (b.we) mem[b.addr] = b.wdata;
        else r.val[8*k +: 8] = b.rdata;
        bus_q.push_back(b);
      end
    end
    res_q.push_back(r);
    bus_start    = cyc + 1;
    exp_ready_at = mop ? -1 : cyc + 1;
    hold_on      = 0;
    wait_left    = pick_wait();
    en         = 1'b1;
    op_in      = o;
    funct3_in  = f3;
    rd_in      = rd;
    result_in  = res;
    store_data = sd;
    @(posedge clk); #2;
    en         = 1'b0;
    op_in      = 7'($urandom);
    funct3_in  = 3'($urandom);
    rd_in      = 4'($urandom);
    result_in  = $urandom;
    store_data = $urandom;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (res_q.size() != 0 && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 500) chk("wait_idle_timeout", 32'(t), 32'd0);
  endtask

  initial begin
    int t;
    logic [6:0]  ro;
    logic [31:0] ra;
    n_cmp = 0;
    n_bad = 0;
    chk_en = 0;
    hold_on = 0;
    fixed_wait = 0;
    wait_left = 0;
    exp_ready_at = -1;
    bus_start = 0;
    rst_n = 1'b0;
    en = 1'b0;
    op_in = '0;
    funct3_in = '0;
    rd_in = '0;
    result_in = '0;
    store_data = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    hold = '{op: '0, f3: '0, rd: '0, val: '0};
    hold_on = 1;
    chk_en = 1;
    chk("rst_val", val, 32'd0);
    chk("rst_rd", {28'd0, reg_addr}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: pass-through op
    issue(OP_ADDI, 3'b000, 4'd5, 32'h1234, 32'h0);
    wait_idle();
    chk("t1_val", val, 32'h0000_1234);
    chk("t1_rd", {28'd0, reg_addr}, 32'd5);

    // 2: lw with 0-wait acks
    mem[32'h100] = 8'h11;
    mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33;
    mem[32'h103] = 8'h44;
    fixed_wait = 0;
    issue(OP_LOAD, 3'b010, 4'd6, 32'h100, 32'h0);
    wait_idle();
    chk("t2_val", val, 32'h4433_2211);

    // 3: lb with 3-cycle stalls
    mem[32'h200] = 8'hF0;
    fixed_wait = 3;
    issue(OP_LOAD, 3'b000, 4'd2, 32'h200, 32'h0);
    wait_idle();
    chk("t3_val", val, 32'h0000_00F0);
    chk("t3_f3", {29'd0, funct3}, 32'd0);

    // 4: sh wrapping at the top of memory
    fixed_wait = 1;
    issue(OP_STORE, 3'b001, 4'd1, 32'hFFFF_FFFF, 32'h0000_BEEF);
    wait_idle();
    chk("t4_val", val, 32'd0);
    chk("t4_memhi", {24'd0, mrd(32'hFFFF_FFFF)}, 32'h0000_00EF);
    chk("t4_memlo", {24'd0, mrd(32'h0)}, 32'h0000_00BE);

    // 5: reset in the middle of a word load
    fixed_wait = 0;
    issue(OP_LOAD, 3'b010, 4'd7, 32'h300, 32'h0);
    t = 0;
    while (bus_q.size() > 2 && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    rst_n = 1'b0;
    chk_en = 0;
    @(posedge clk); #2;
    bus_q.delete();
    res_q.delete();
    exp_ready_at = -1;
    hold = '{op: '0, f3: '0, rd: '0, val: '0};
    hold_on = 1;
    chk_en = 1;
    chk("t5_req", {31'd0, mem_req}, 32'd0);
    chk("t5_val", val, 32'd0);
    chk("t5_op", {25'd0, op}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    issue(OP_ADDI, 3'b000, 4'd9, 32'hCAFE, 32'h0);
    wait_idle();
    chk("t5_addi", val, 32'h0000_CAFE);

    // 6: stray en pulses during a word load
    fixed_wait = 1;
    issue(OP_LOAD, 3'b010, 4'd3, 32'h100, 32'h0);
    repeat (2) begin
      en = 1'b1;
      op_in = OP_ADDI;
      rd_in = 4'hC;
      result_in = $urandom;
      @(posedge clk); #2;
    end
    en = 1'b0;
    wait_idle();
    chk("t6_rd", {28'd0, reg_addr}, 32'd3);
    chk("t6_val", val, 32'h4433_2211);

    // Random mix of loads, stores and other ops
    fixed_wait = -1;
    for (int i = 0; i < 200; i++) begin
      t = $urandom_range(0, 9);
      if (t < 4) ro = OP_LOAD;
      else if (t < 7) ro = OP_STORE;
      else begin
        ro = 7'($urandom);
        if (ro == OP_LOAD || ro == OP_STORE) ro = OP_ADDI;
      end
      if ($urandom_range(0, 3) == 0)
        ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else
        ra = 32'h1000 + 32'($urandom_range(0, 63));
      issue(ro, 3'($urandom), 4'($urandom), ra, $urandom);
      wait_idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
